timer_irq_slave: RTL and testbench

Memory-mapped timer peripheral on the core's single-master bus, downstream of the core's `M_wb_*` master port. It decodes an address window, completes reads and writes with a one-cycle `ack` after a programmable number of wait states, and runs a prescaled 32-bit up-counter with compare. It drives the level-sensitive `Irq` input of the core.

---
 rtl/timer_irq_slave.sv | 177 +++++++++++++++++
 tb/tb_timer_irq_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_irq_slave.sv
// Memory-mapped timer peripheral: a 32-byte register window with programmable wait states,
// a prescaled up-counter with compare and one-shot/auto-reload modes, and a level interrupt.
module timer_irq_slave #(
    parameter int                ADDR_W      = 32,
    parameter int                WORD_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_1000),
    parameter int                WAIT_STATES = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] S_wb_addr,
    input  logic              S_wb_cs,
    input  logic              S_wb_we,
    input  logic [WORD_W-1:0] S_wb_wdata,
    output logic [WORD_W-1:0] S_wb_rdata,
    output logic              S_wb_ack,
    output logic              Irq
);

    localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_COUNT    = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_ws_cnt;
    logic [2:0]        r_off;
    logic              r_we;
    logic [WORD_W-1:0] r_wdata;

    logic              r_en;
    logic              r_auto;
    logic              r_irq_en;
    logic              r_match;
    logic [WORD_W-1:0] r_count;
    logic [WORD_W-1:0] r_compare;
    logic [WORD_W-1:0] r_prescale;
    logic [WORD_W-1:0] r_pre_cnt;
    logic              r_irq;

    logic              w_sel;
    logic              w_accept;
    logic              w_commit;
    logic              w_wr_ctrl;
    logic              w_wr_count;
    logic              w_wr_compare;
    logic              w_wr_status;
    logic              w_wr_prescale;
    logic              w_tick;
    logic              w_cmp_eq;
    logic [WORD_W-1:0] w_rd_data;
    logic              w_unused_ok;

    assign w_sel       = S_wb_cs && (S_wb_addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
    assign w_accept    = (r_state == ST_IDLE) && w_sel;
    assign w_unused_ok = ^S_wb_addr[1:0];

    // Writes take effect on the edge that closes the ACK cycle.
    assign w_commit      = (r_state == ST_ACK) && r_we;
    assign w_wr_ctrl     = w_commit && (r_off == OFF_CTRL);
    assign w_wr_count    = w_commit && (r_off == OFF_COUNT);
    assign w_wr_compare  = w_commit && (r_off == OFF_COMPARE);
    assign w_wr_status   = w_commit && (r_off == OFF_STATUS);
    assign w_wr_prescale = w_commit && (r_off == OFF_PRESCALE);

    assign w_tick   = r_en && (r_pre_cnt == r_prescale);
    assign w_cmp_eq = (r_count == r_compare);

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state  <= ST_IDLE;
            r_ws_cnt <= 4'd0;
            r_off    <= 3'd0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ws_cnt <= (r_state == ST_WAIT) ? r_ws_cnt + 4'd1 : 4'd0;
            if (w_accept) begin
                r_off   <= S_wb_addr[4:2];
                r_we    <= S_wb_we;
                r_wdata <= S_wb_wdata;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd_data    = '0;
        case (r_off)
            OFF_CTRL:     w_rd_data[2:0] = {r_irq_en, r_auto, r_en};
            OFF_COUNT:    w_rd_data      = r_count;
            OFF_COMPARE:  w_rd_data      = r_compare;
            OFF_STATUS:   w_rd_data[0]   = r_match;
            OFF_PRESCALE: w_rd_data      = r_prescale;
            default:      w_rd_data      = '0;
        endcase
        case (r_state)
            ST_IDLE: if (w_sel) w_state_next = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
            ST_WAIT: if (r_ws_cnt == WS_LAST) w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        S_wb_ack   = (r_state == ST_ACK);
        S_wb_rdata = (r_state == ST_ACK) ? w_rd_data : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_pre_cnt <= '0;
        end else if (w_wr_prescale || !r_en || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + WORD_W'(1);
        end
    end

    // A bus write to a field wins over what the tick would do to that field.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_count    <= '0;
            r_compare  <= '0;
            r_prescale <= '0;
            r_match    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= r_wdata[0];
                r_auto   <= r_wdata[1];
                r_irq_en <= r_wdata[2];
            end else if (w_tick && w_cmp_eq && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr_count) begin
                r_count <= r_wdata;
            end else if (w_tick) begin
                if (!w_cmp_eq) begin
                    r_count <= r_count + WORD_W'(1);
                end else if (r_auto) begin
                    r_count <= '0;
                end
            end

            if (w_wr_compare) begin
                r_compare <= r_wdata;
            end
            if (w_wr_prescale) begin
                r_prescale <= r_wdata;
            end

            if (w_tick && w_cmp_eq) begin
                r_match <= 1'b1;
            end else if (w_wr_status && r_wdata[0]) begin
                r_match <= 1'b0;
            end

            r_irq <= r_match && r_irq_en;
        end
    end

    assign Irq = r_irq;

endmodule

// File: tb/tb_timer_irq_slave.sv
// Directed self-checking bench for timer_irq_slave with two wait states.
module tb_timer_irq_slave;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_CNT  = BASE + 32'h04;
    localparam logic [31:0] A_CMP  = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_PRE  = BASE + 32'h10;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        cs;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    timer_irq_slave #(
        .ADDR_W     (32),
        .WORD_W     (32),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(2)
    ) dut (
        .Clk       (clk),
        .Rst       (rst_n),
        .S_wb_addr (addr),
        .S_wb_cs   (cs),
        .S_wb_we   (we),
        .S_wb_wdata(wdata),
        .S_wb_rdata(rdata),
        .S_wb_ack  (ack),
        .Irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; returns at the sample point of the ack cycle.
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output int lat);
        addr  = a;
        we    = w;
        wdata = d;
        cs    = 1'b1;
        lat   = 0;
        rd    = '0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ack && lat < 40);
        rd = rdata;
        if (!ack) check_value("ack_timeout", {31'd0, ack}, 32'd1);
        cs = 1'b0;
        we = 1'b0;
        $display("bus %s addr=%h wdata=%h rdata=%h lat=%0d", w ? "wr" : "rd", a, d, rd, lat);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        int l;
        bus_xfer(1'b1, a, d, dummy, l);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        int l;
        bus_xfer(1'b0, a, 32'd0, d, l);
        check_value(tag, d, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          lat;
        int          acks;

        rst_n = 1'b0;
        cs    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_ack", {31'd0, ack}, 32'd0);
        check_value("rst_irq", {31'd0, irq}, 32'd0);
        check_value("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All offsets read zero after reset; ack three cycles after cs, one cycle wide.
        for (int i = 0; i < 8; i++) begin
            bus_xfer(1'b0, BASE + 32'(i * 4), 32'd0, d, lat);
            check_value("reset_read", d, 32'd0);
            check_value("read_latency", lat, 32'd3);
            @(posedge clk);
            #1;
            check_value("ack_width", {31'd0, ack}, 32'd0);
            check_value("rdata_idle", rdata, 32'd0);
        end

        // Out-of-window access: never acked, nothing written.
        addr  = BASE + 32'h40;
        we    = 1'b1;
        wdata = 32'h7;
        cs    = 1'b1;
        acks  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        cs = 1'b0;
        we = 1'b0;
        @(posedge clk);
        #1;
        check_value("oow_ack", acks, 32'd0);
        rd_check("oow_ctrl", A_CTRL, 32'd0);

        // Auto-reload: 6 ticks of 4 cycles from the CTRL commit edge to the match.
        wr(A_PRE, 32'd3);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'b111);
        repeat (22) @(posedge clk);
        #1;
        check_value("auto_irq_early", {31'd0, irq}, 32'd0);
        bus_xfer(1'b0, A_CNT, 32'd0, d, lat);
        check_value("auto_count_reload", d, 32'd0);
        check_value("auto_irq_pre", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        check_value("auto_irq_rise", {31'd0, irq}, 32'd1);
        repeat (30) @(posedge clk);
        #1;
        check_value("auto_irq_hold", {31'd0, irq}, 32'd1);
        rd_check("auto_status", A_STAT, 32'd1);
        wr(A_CTRL, 32'd0);
        wr(A_STAT, 32'd1);
        wr(A_CNT, 32'd0);

        // One-shot: count stops at COMPARE, en self-clears, W1C drops the interrupt.
        wr(A_PRE, 32'd0);
        wr(A_CMP, 32'd2);
        wr(A_CTRL, 32'b101);
        repeat (10) @(posedge clk);
        #1;
        rd_check("oneshot_count", A_CNT, 32'd2);
        rd_check("oneshot_ctrl", A_CTRL, 32'b100);
        rd_check("oneshot_status", A_STAT, 32'd1);
        check_value("oneshot_irq", {31'd0, irq}, 32'd1);
        wr(A_STAT, 32'd1);
        check_value("w1c_irq_ack", {31'd0, irq}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_value("w1c_irq_fall", {31'd0, irq}, 32'd0);
        rd_check("w1c_status", A_STAT, 32'd0);

        // Wrap from all-ones to zero does not match; reaching COMPARE does.
        wr(A_CTRL, 32'd0);
        wr(A_PRE, 32'd1);
        wr(A_CMP, 32'd10);
        wr(A_CNT, 32'hFFFF_FFFF);
        wr(A_CTRL, 32'b001);
        rd_check("wrap_count", A_CNT, 32'd0);
        rd_check("wrap_status", A_STAT, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        rd_check("wrap_match", A_STAT, 32'd1);
        rd_check("wrap_count_hold", A_CNT, 32'd10);
        rd_check("wrap_ctrl", A_CTRL, 32'd0);
        check_value("wrap_irq", {31'd0, irq}, 32'd0);

        // Every cycle is a matching tick, so W1C always collides with a match set.
        wr(A_STAT, 32'd1);
        wr(A_PRE, 32'd0);
        wr(A_CMP, 32'd0);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'b111);
        repeat (3) @(posedge clk);
        #1;
        check_value("race_irq_before", {31'd0, irq}, 32'd1);
        wr(A_STAT, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_value("race_irq_after", {31'd0, irq}, 32'd1);
        rd_check("race_status", A_STAT, 32'd1);

        // Reset while in WAIT aborts the CTRL write.
        addr  = A_CTRL;
        we    = 1'b1;
        wdata = 32'b111;
        cs    = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cs    = 1'b0;
        we    = 1'b0;
        @(posedge clk);
        #1;
        check_value("midrst_ack", {31'd0, ack}, 32'd0);
        check_value("midrst_irq", {31'd0, irq}, 32'd0);
        check_value("midrst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        acks  = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ack) acks++;
        end
        check_value("midrst_no_ack", acks, 32'd0);
        rd_check("midrst_ctrl", A_CTRL, 32'd0);
        rd_check("midrst_count", A_CNT, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
